n64_controller_responder: RTL
=============================

// Module: n64_controller_responder
// PURPOSE
//  Device-side end of the N64 single-wire joybus: emulates a controller so the console-side poller and paddle logic can be
//  exercised without real hardware. Decodes host command bytes from the open-drain line, then replies with status or with
//  button/stick state from its input ports. Sits on the same dataController net as the host poller (bench or FPGA loopback).
// PARAMETERS
//  CYCLES_PER_US   50    clk cycles per microsecond; all bus timing derives from it (min 8)
//  RESP_DELAY_US   2     quiet time between host stop-bit release and first reply bit
//  TIMEOUT_US      8     max low or mid-frame high time before the frame is aborted
// PORTS
//  clk             in    1   system clock
//  rst             in    1   asynchronous, active-low reset
//  dataController  inout 1   open-drain bus; driven 1'b0 or 'z only, never 1'b1
//  buttons         in    16  A,B,Z,Start,Up,Down,Left,Right,rsv,rsv,L,R,C-Up,C-Down,C-Left,C-Right (bit15 = A)
//  stick_x         in    8   signed X axis
//  stick_y         in    8   signed Y axis
//  poll_strobe     out   1   one-cycle pulse when a 0x01 reply starts
//  cmd_error       out   1   one-cycle pulse on unknown command, bad stop bit or timeout
// BEHAVIOUR
//  Reset (async assert, sync deassert): line released ('z), state IDLE, poll_strobe=0, cmd_error=0, counters cleared.
//  Input path: 2-flop synchronizer on dataController; edges are detected on the synced value; sampling is ignored while driving.
//  Bit decode: low time measured falling->rising; low < 2us -> '1', low >= 2us -> '0'. Bytes are MSB first.
//  FSM: IDLE -> RX_BITS (first falling edge) -> RX_STOP (8 bits in) -> GAP -> TX_LOW -> TX_HIGH ... -> TX_STOP -> IDLE.
//   RX_STOP: 9th low pulse must be < 2us; otherwise cmd_error, go to IDLE after line high.
//   Decode on stop-bit rising edge: 0x00 or 0xFF -> reply 0x05,0x00,0x02; 0x01 -> reply buttons,stick_x,stick_y (4 bytes).
//   Other codes: cmd_error pulse, no reply, IDLE.
//   Reply data is snapshotted in the decode cycle; input changes during TX do not affect the frame.
//  GAP: exactly RESP_DELAY_US*CYCLES_PER_US cycles after the synced stop-bit rising edge; the line then goes low.
//  TX bit = 4us cell: '1' -> 1us low + 3us released; '0' -> 3us low + 1us released. TX_STOP: 2us low, then release, IDLE.
//  poll_strobe pulses in the same cycle the first 0x01 reply bit drives low.
//  Timeouts: low > TIMEOUT_US or high > TIMEOUT_US between RX bits -> cmd_error, IDLE (next falling edge starts a new frame).
//  Bus contention: falling edges during GAP/TX are ignored; the frame always completes.
//  Reset mid-TX: line released asynchronously in the same cycle that rst falls; no partial stop bit is sent.
//  Counters are sized $clog2(4*CYCLES_PER_US*TIMEOUT_US); bit counter wraps 0..7 per byte, byte counter 0..3.
// CONFIGURATION
//  N64_RESP_STATS_EN defined: extra outputs poll_count[15:0] and error_count[7:0], incremented on poll_strobe and cmd_error.
//   Both saturate (no wrap) and clear on reset.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  Package n64_pkg: command codes (CMD_STATUS 8'h00, CMD_POLL 8'h01, CMD_RESET 8'hFF), status bytes {8'h05,8'h00,8'h02},
//   FSM state enum, and bit-threshold helpers taking CYCLES_PER_US.
//  Sub-module n64_bit_encoder: serialises one byte plus an optional stop bit onto oe_n; the responder sequences bytes.
// TESTING
//  Host sends 0x01 + stop, buttons=16'h8000, x=8'h10, y=8'hF0 -> after 2us, reply 80 00 10 F0 + 2us stop; poll_strobe=1 once.
//  Host sends 0x00 -> reply 05 00 02 + stop; 0xFF -> identical reply; poll_strobe stays 0.
//  Host sends 0x55 -> no line activity for 50us; cmd_error pulses once.
//  Host holds line low 10us mid-byte -> cmd_error; a following valid 0x01 is answered normally.
//  rst falls during 2nd reply byte -> line released the same cycle; after release, 0x01 is answered correctly.
//  With N64_RESP_STATS_EN: 3 polls + 1 bad command -> poll_count=3, error_count=1.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared joybus definitions for the N64 controller responder: command codes,
// status reply bytes, FSM state encodings and bit-timing helpers.
package n64_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] STATUS_B0 = 8'h05;
    localparam logic [7:0] STATUS_B1 = 8'h00;
    localparam logic [7:0] STATUS_B2 = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_BITS,
        ST_RX_STOP,
        ST_GAP,
        ST_TX
    } resp_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOW,
        TX_HIGH,
        TX_STOP
    } enc_state_t;

    // Wide enough for a full 4us cell and for the longest tolerated low/high time.
    function automatic int unsigned counter_width(input int unsigned cycles_per_us,
                                                  input int unsigned timeout_us);
        return $clog2(4 * cycles_per_us * timeout_us);
    endfunction

    // Host low pulses shorter than this decode as '1'.
    function automatic int unsigned one_threshold(input int unsigned cycles_per_us);
        return 2 * cycles_per_us;
    endfunction

endpackage

// File: rtl/n64_bit_encoder.sv
// Serialises one byte (MSB first) plus an optional 2us stop bit onto the
// active-low output enable of the joybus line.
module n64_bit_encoder
    import n64_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned CW            = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       stop,
    output logic       oe_n,
    output logic       byte_done,
    output logic       frame_done
);

    localparam logic [CW-1:0] ONE_LOW   = CW'(CYCLES_PER_US);
    localparam logic [CW-1:0] ZERO_LOW  = CW'(3 * CYCLES_PER_US);
    localparam logic [CW-1:0] CELL_LAST = CW'(4 * CYCLES_PER_US - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(2 * CYCLES_PER_US - 1);

    enc_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          with_stop;
    logic [CW-1:0] low_len;

    assign low_len    = shreg[7] ? ONE_LOW : ZERO_LOW;
    // Asserted in the last cycle of a byte so the sequencer can load the next
    // byte on the same edge and keep bit cells back to back.
    assign byte_done  = (state == TX_HIGH) && (cnt == CELL_LAST) &&
                        (bit_idx == 3'd7) && !with_stop;
    assign frame_done = (state == TX_STOP) && (cnt == STOP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            with_stop <= 1'b0;
            oe_n      <= 1'b1;
        end else if (start) begin
            state     <= TX_LOW;
            cnt       <= '0;
            shreg     <= data;
            bit_idx   <= '0;
            with_stop <= stop;
            oe_n      <= 1'b0;
        end else begin
            case (state)
                TX_LOW: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == low_len - CW'(1)) begin
                        oe_n  <= 1'b1;
                        state <= TX_HIGH;
                    end
                end
                TX_HIGH: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CELL_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (with_stop) begin
                                oe_n  <= 1'b0;
                                state <= TX_STOP;
                            end else begin
                                state <= TX_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            oe_n    <= 1'b0;
                            state   <= TX_LOW;
                        end
                    end
                end
                TX_STOP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == STOP_LAST) begin
                        oe_n  <= 1'b1;
                        state <= TX_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    oe_n  <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/n64_controller_responder.sv
// Device-side N64 joybus endpoint: decodes host command bytes and answers with
// status or pad state. Define N64_RESP_STATS_EN for saturating poll/error counters.
module n64_controller_responder
    import n64_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned RESP_DELAY_US = 2,
    parameter int unsigned TIMEOUT_US    = 8
) (
    input  logic        clk,
    input  logic        rst,
    inout  logic        dataController,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    output logic        poll_strobe,
    output logic        cmd_error
`ifdef N64_RESP_STATS_EN
    ,
    output logic [15:0] poll_count,
    output logic [7:0]  error_count
`endif
);

    localparam int unsigned   CW          = counter_width(CYCLES_PER_US, TIMEOUT_US);
    localparam logic [CW-1:0] BIT_THRESH  = CW'(one_threshold(CYCLES_PER_US));
    localparam logic [CW-1:0] TIMEOUT_CYC = CW'(TIMEOUT_US * CYCLES_PER_US);
    // Counting starts at 1 in the cycle after the synced stop-bit rise, so the
    // line goes low exactly RESP_DELAY_US after that rise.
    localparam logic [CW-1:0] GAP_START   = CW'(RESP_DELAY_US * CYCLES_PER_US - 1);

    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= '0;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic sync_meta, sync_line, sync_prev;
    logic fall, rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= dataController;
            sync_line <= sync_meta;
            sync_prev <= sync_line;
        end
    end
    assign fall = sync_prev & ~sync_line;
    assign rise = ~sync_prev & sync_line;

    resp_state_t     state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      cmd_shift;
    logic [3:0][7:0] reply;
    logic [1:0]      byte_idx;
    logic [1:0]      last_idx;
    logic            is_poll;
    logic            rx_one;

    logic            enc_start;
    logic [1:0]      next_idx;
    logic            enc_oe_n;
    logic            enc_byte_done;
    logic            enc_frame_done;

    assign rx_one = (cnt < BIT_THRESH);

    always_comb begin
        enc_start = 1'b0;
        next_idx  = '0;
        if (state == ST_GAP && cnt == GAP_START) begin
            enc_start = 1'b1;
        end else if (state == ST_TX && enc_byte_done) begin
            enc_start = 1'b1;
            next_idx  = byte_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            cmd_shift   <= '0;
            reply       <= '0;
            byte_idx    <= '0;
            last_idx    <= '0;
            is_poll     <= 1'b0;
            poll_strobe <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            poll_strobe <= 1'b0;
            cmd_error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt     <= CW'(1);
                        bit_cnt <= '0;
                        state   <= ST_RX_BITS;
                    end
                end
                // Both RX states time the current level from the last edge;
                // rising edges close a low pulse and carry its value.
                ST_RX_BITS, ST_RX_STOP: begin
                    if (fall) begin
                        cnt <= CW'(1);
                    end else if (rise) begin
                        cnt <= CW'(1);
                        if (state == ST_RX_BITS) begin
                            cmd_shift <= {cmd_shift[6:0], rx_one};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ST_RX_STOP;
                        end else if (!rx_one) begin
                            cmd_error <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            case (cmd_shift)
                                CMD_STATUS, CMD_RESET: begin
                                    reply    <= {8'h00, STATUS_B2, STATUS_B1, STATUS_B0};
                                    last_idx <= 2'd2;
                                    is_poll  <= 1'b0;
                                    state    <= ST_GAP;
                                end
                                CMD_POLL: begin
                                    reply    <= {stick_y, stick_x, buttons[7:0], buttons[15:8]};
                                    last_idx <= 2'd3;
                                    is_poll  <= 1'b1;
                                    state    <= ST_GAP;
                                end
                                default: begin
                                    cmd_error <= 1'b1;
                                    state     <= ST_IDLE;
                                end
                            endcase
                        end
                    end else if (cnt >= TIMEOUT_CYC) begin
                        cmd_error <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == GAP_START) begin
                        byte_idx    <= '0;
                        poll_strobe <= is_poll;
                        state       <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (enc_byte_done) byte_idx <= byte_idx + 2'd1;
                    else if (enc_frame_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    n64_bit_encoder #(
        .CYCLES_PER_US(CYCLES_PER_US),
        .CW           (CW)
    ) u_encoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (enc_start),
        .data      (reply[next_idx]),
        .stop      (next_idx == last_idx),
        .oe_n      (enc_oe_n),
        .byte_done (enc_byte_done),
        .frame_done(enc_frame_done)
    );

    assign dataController = enc_oe_n ? 1'bz : 1'b0;

`ifdef N64_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_count  <= '0;
            error_count <= '0;
        end else begin
            if (poll_strobe && poll_count != '1) poll_count <= poll_count + 16'd1;
            if (cmd_error && error_count != '1) error_count <= error_count + 8'd1;
        end
    end
`endif

endmodule
